// File: rtl/analyzer_readback_fsm_pkg.sv
`default_nettype none
// ============================================================================
// Module      : analyzer_readback_fsm_pkg
// Description : Shared types and constants for the trace-buffer readback FSM.
// Revision    : 1.0 - initial release
// ============================================================================
package analyzer_readback_fsm_pkg;

    localparam int C_ADDR_BITS = 25;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // A width of 32 yields all ones because the shift overflows to zero.
    function automatic logic [31:0] addr_mask(input int bits);
        return (32'd1 << bits) - 32'd1;
    endfunction

    localparam logic [31:0] C_ADDR_MASK = addr_mask(C_ADDR_BITS);

endpackage
`default_nettype wire

// File: rtl/analyzer_readback_fsm.sv
`default_nettype none
// ============================================================================
// Module      : analyzer_readback_fsm
// Description : Walks trace-buffer addresses Begin..End (inclusive, wrapping)
//               issuing one read request per downstream grant.
// Revision    : 1.0 - initial release
// ============================================================================
module analyzer_readback_fsm
    import analyzer_readback_fsm_pkg::*;
#(
    parameter int ADDR_BITS = C_ADDR_BITS
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        idle,
    input  logic        read_trace_data,
    input  logic [31:0] sampleNumber_Begin,
    input  logic [31:0] sampleNumber_End,
    input  logic        read_allowed,
    output logic        read_req,
    output logic [31:0] readSampleNumber
);

    localparam logic [31:0] c_mask = addr_mask(ADDR_BITS);

    state_t      r_state;
    logic        r_read_req;
    logic [31:0] r_addr;
    logic [31:0] r_end;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_read_req <= 1'b0;
            r_addr     <= 32'd0;
            r_end      <= 32'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_read_req <= 1'b0;
                    if (idle && read_trace_data) begin
                        r_addr     <= sampleNumber_Begin & c_mask;
                        r_end      <= sampleNumber_End & c_mask;
                        r_read_req <= 1'b1;
                        r_state    <= ST_READ;
                    end
                end
                ST_READ: begin
                    // Sampler leaving idle wins over a coincident grant.
                    if (!idle) begin
                        r_read_req <= 1'b0;
                        r_state    <= ST_IDLE;
                    end else if (read_allowed) begin
                        if (r_addr == r_end) begin
                            r_read_req <= 1'b0;
                            r_state    <= ST_DONE;
                        end else begin
                            r_addr <= (r_addr + 32'd1) & c_mask;
                        end
                    end
                end
                ST_DONE: begin
                    r_read_req <= 1'b0;
                    r_state    <= ST_IDLE;
                end
                default: begin
                    r_read_req <= 1'b0;
                    r_state    <= ST_IDLE;
                end
            endcase
        end
    end

    assign read_req         = r_read_req;
    assign readSampleNumber = r_addr;

endmodule
`default_nettype wire

// File: tb/tb_analyzer_readback_fsm.sv
`default_nettype none
// ============================================================================
// Module      : tb_analyzer_readback_fsm
// Description : Directed self-checking bench for analyzer_readback_fsm.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_analyzer_readback_fsm;
    import analyzer_readback_fsm_pkg::*;

    localparam logic [31:0] MASK = 32'h01FF_FFFF;

    logic        clk;
    logic        reset;
    logic        idle;
    logic        read_trace_data;
    logic [31:0] sampleNumber_Begin;
    logic [31:0] sampleNumber_End;
    logic        read_allowed;
    logic        read_req;
    logic [31:0] readSampleNumber;

    int total = 0;
    int bad   = 0;

    analyzer_readback_fsm dut (
        .clk                (clk),
        .reset              (reset),
        .idle               (idle),
        .read_trace_data    (read_trace_data),
        .sampleNumber_Begin (sampleNumber_Begin),
        .sampleNumber_End   (sampleNumber_End),
        .read_allowed       (read_allowed),
        .read_req           (read_req),
        .readSampleNumber   (readSampleNumber)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start(input logic [31:0] b, input logic [31:0] e);
        sampleNumber_Begin = b;
        sampleNumber_End   = e;
        read_trace_data    = 1'b1;
        tick();
        read_trace_data    = 1'b0;
        sampleNumber_Begin = 32'h55;
        sampleNumber_End   = 32'h3;
        chk("start_req", 32'(read_req), 32'd1);
        chk("start_addr", readSampleNumber, b & MASK);
    endtask

    // mode 0: grant always high; mode 1: random grant with a forced stall
    task automatic run(input logic [31:0] b, input int expn, input int mode);
        logic [31:0] exp_a;
        int n;
        int cyc;
        exp_a = b & MASK;
        n = 0;
        cyc = 0;
        while (read_req && cyc < 400) begin
            if (mode == 1)
                read_allowed = (cyc == 2) ? 1'b0 : 1'($urandom_range(0, 1));
            else
                read_allowed = 1'b1;
            read_trace_data = (cyc == 4);
            if (read_allowed) begin
                chk("xfer_addr", readSampleNumber, exp_a);
                exp_a = (exp_a + 32'd1) & MASK;
                n++;
                tick();
            end else begin
                tick();
                chk("stall_hold", readSampleNumber, exp_a);
                chk("stall_req", 32'(read_req), 32'd1);
            end
            cyc++;
        end
        read_trace_data = 1'b0;
        read_allowed    = 1'b0;
        chk("xfer_count", 32'(n), 32'(expn));
        chk("end_req", 32'(read_req), 32'd0);
        chk("end_state", 32'(dut.r_state), 32'(ST_DONE));
        chk("done_addr", readSampleNumber, ((b & MASK) + 32'(expn) - 32'd1) & MASK);
        read_trace_data = 1'b1;
        tick();
        read_trace_data = 1'b0;
        chk("back_idle", 32'(dut.r_state), 32'(ST_IDLE));
        chk("back_req", 32'(read_req), 32'd0);
        tick();
        chk("no_restart", 32'(read_req), 32'd0);
    endtask

    initial begin
        reset              = 1'b0;
        idle               = 1'b0;
        read_trace_data    = 1'b0;
        sampleNumber_Begin = 32'd0;
        sampleNumber_End   = 32'd0;
        read_allowed       = 1'b0;
        #2 reset = 1'b1;
        #1;
        chk("rst_req", 32'(read_req), 32'd0);
        chk("rst_addr", readSampleNumber, 32'd0);
        chk("rst_state", 32'(dut.r_state), 32'(ST_IDLE));
        tick();
        #3 reset = 1'b0;

        // Start pulse while the sampler is busy must be ignored
        for (int i = 0; i < 3; i++) tick();
        sampleNumber_Begin = 32'd7;
        sampleNumber_End   = 32'd106;
        read_trace_data    = 1'b1;
        tick();
        read_trace_data    = 1'b0;
        chk("gate_req", 32'(read_req), 32'd0);
        chk("gate_state", 32'(dut.r_state), 32'(ST_IDLE));
        for (int i = 0; i < 6; i++) tick();
        chk("gate_req2", 32'(read_req), 32'd0);

        idle = 1'b1;
        for (int i = 0; i < 5; i++) tick();

        start(32'd7, 32'd106);
        run(32'd7, 100, 0);

        start(32'd7, 32'd106);
        run(32'd7, 100, 1);

        start(32'hFE00_0000 | 32'd33554416, 32'hA000_0000 | 32'd19);
        run(32'd33554416, 36, 0);

        start(32'd5, 32'd5);
        run(32'd5, 1, 0);

        // Abort mid-readback; the coincident grant is not a transfer
        start(32'd7, 32'd106);
        read_allowed = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        chk("pre_abort_addr", readSampleNumber, 32'd10);
        idle = 1'b0;
        tick();
        chk("abort_req", 32'(read_req), 32'd0);
        chk("abort_state", 32'(dut.r_state), 32'(ST_IDLE));
        chk("abort_addr", readSampleNumber, 32'd10);
        tick();
        chk("abort_req2", 32'(read_req), 32'd0);
        read_allowed = 1'b0;
        idle = 1'b1;
        tick();
        start(32'd7, 32'd106);
        run(32'd7, 100, 0);

        // Asynchronous reset in the middle of a cycle
        start(32'd7, 32'd106);
        read_allowed = 1'b1;
        tick();
        tick();
        chk("pre_rst_addr", readSampleNumber, 32'd9);
        #3 reset = 1'b1;
        #1;
        chk("arst_req", 32'(read_req), 32'd0);
        chk("arst_addr", readSampleNumber, 32'd0);
        chk("arst_state", 32'(dut.r_state), 32'(ST_IDLE));
        #2 reset = 1'b0;
        tick();
        chk("post_rst_req", 32'(read_req), 32'd0);
        read_allowed = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
